pdp8_iot_seq: RTL and testbench

PDP8_IOT_SEQ -- requirements
Module: pdp8_iot_seq

---
 rtl/pdp8_iot_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_pdp8_iot_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp8_iot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pdp8_iot_seq
//  Description : PDP-8 IOT (input/output transfer) sequencer. Latches an IOT
//                instruction, steps through the IOP1/IOP2/IOP4 pulse phases
//                selected by mb[2:0], samples device responses at the end of
//                each pulse and turns them into skip / AC-clear / AC-load
//                requests. Device 00 is handled internally as the interrupt
//                control (ION 6001 / IOF 6002) with a one-instruction ION
//                delay, and a fixed-priority interrupt request encoder.
//  Ports       : clk, reset (sync, active low)
//                iot_start, mb[11:0]           - IOT request from the CPU
//                io_select[5:0], iop[2:0]      - device select and IOP pulses
//                dev_skip, dev_clear_ac, dev_data_avail, dev_data[11:0]
//                skip, ac_clear, ac_load, ac_data[11:0], iot_done
//                irq_in[3:0], instr_fetch, int_ack
//                ion, int_req, int_src[1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module pdp8_iot_seq #(
    parameter int IOP_CYCLES = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iot_start,
    input  logic [11:0] mb,
    output logic [5:0]  io_select,
    output logic [2:0]  iop,
    input  logic        dev_skip,
    input  logic        dev_clear_ac,
    input  logic        dev_data_avail,
    input  logic [11:0] dev_data,
    output logic        skip,
    output logic        ac_clear,
    output logic        ac_load,
    output logic [11:0] ac_data,
    output logic        iot_done,
    input  logic [3:0]  irq_in,
    input  logic        instr_fetch,
    input  logic        int_ack,
    output logic        ion,
    output logic        int_req,
    output logic [1:0]  int_src
);

    // Phase counters hold "cycles remaining minus one", so 2 bits cover 1..4.
    localparam logic [1:0] c_IOP_LAST = 2'(IOP_CYCLES - 1);
    localparam logic [1:0] c_GAP_LAST = 2'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SETUP = 4'd1,
        S_P1    = 4'd2,
        S_G1    = 4'd3,
        S_P2    = 4'd4,
        S_G2    = 4'd5,
        S_P4    = 4'd6,
        S_G4    = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next_phase;
    logic [1:0]  r_cnt;
    logic [2:0]  r_bits;
    logic [5:0]  r_sel;
    logic [2:0]  r_iop;
    logic        r_skip;
    logic        r_ac_clear;
    logic        r_ac_load;
    logic [11:0] r_ac_data;
    logic        r_iot_done;
    logic        r_ion;
    logic        r_ion_pending;
    logic [2:0]  w_next_iop;
    logic        w_internal;
    logic        w_last;
    logic        w_done_internal;
    logic [1:0]  w_int_src;
    logic        w_unused_mb;

    // Opcode field of mb is decoded by the CPU, not here.
    assign w_unused_mb = &{1'b0, mb[11:9]};

    assign w_internal      = (r_sel == 6'o00);
    assign w_last          = (r_cnt == 2'd0);
    assign w_done_internal = (r_state == S_DONE) && w_internal;

    // Phase that follows the current SETUP/Gn state: the next enabled IOP
    // in P1, P2, P4 order, or DONE when none remain.
    always_comb begin
        w_next_phase = S_DONE;
        case (r_state)
            S_SETUP: begin
                if (r_bits[0])      w_next_phase = S_P1;
                else if (r_bits[1]) w_next_phase = S_P2;
                else if (r_bits[2]) w_next_phase = S_P4;
            end
            S_G1: begin
                if (r_bits[1])      w_next_phase = S_P2;
                else if (r_bits[2]) w_next_phase = S_P4;
            end
            S_G2: begin
                if (r_bits[2])      w_next_phase = S_P4;
            end
            default: w_next_phase = S_DONE;
        endcase
    end

    // Device 00 keeps its phase timing but never drives an IOP line.
    always_comb begin
        w_next_iop = 3'b000;
        case (w_next_phase)
            S_P1:    w_next_iop = 3'b001;
            S_P2:    w_next_iop = 3'b010;
            S_P4:    w_next_iop = 3'b100;
            default: w_next_iop = 3'b000;
        endcase
        if (w_internal) begin
            w_next_iop = 3'b000;
        end
    end

    // Sequencer: all outputs registered, set on the transition into the
    // state in which they must be visible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_bits     <= 3'b000;
            r_sel      <= 6'o00;
            r_iop      <= 3'b000;
            r_skip     <= 1'b0;
            r_ac_clear <= 1'b0;
            r_ac_load  <= 1'b0;
            r_ac_data  <= 12'o0000;
            r_iot_done <= 1'b0;
        end else begin
            // One-cycle pulses default low.
            r_ac_clear <= 1'b0;
            r_ac_load  <= 1'b0;
            r_iot_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iot_start) begin
                        r_bits  <= mb[2:0];
                        r_sel   <= mb[8:3];
                        r_skip  <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP, S_G1, S_G2, S_G4: begin
                    // SETUP is always a single cycle; gaps run their count.
                    if ((r_state == S_SETUP) || w_last) begin
                        r_state    <= w_next_phase;
                        r_cnt      <= c_IOP_LAST;
                        r_iop      <= w_next_iop;
                        r_iot_done <= (w_next_phase == S_DONE);
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_P1, S_P2, S_P4: begin
                    if (w_last) begin
                        r_iop <= 3'b000;
                        r_cnt <= c_GAP_LAST;
                        case (r_state)
                            S_P1:    r_state <= S_G1;
                            S_P2:    r_state <= S_G2;
                            default: r_state <= S_G4;
                        endcase
                        // Responses captured on the last pulse cycle appear
                        // during the first gap cycle.
                        if (!w_internal) begin
                            r_skip     <= r_skip | dev_skip;
                            r_ac_clear <= dev_clear_ac;
                            r_ac_load  <= dev_data_avail;
                            if (dev_data_avail) begin
                                r_ac_data <= dev_data;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_iop   <= 3'b000;
                end
            endcase
        end
    end

    // Interrupt enable. ION arms a pending flag that is promoted on the next
    // instruction fetch; IOF beats ION, and int_ack beats everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ion         <= 1'b0;
            r_ion_pending <= 1'b0;
        end else if (int_ack) begin
            r_ion         <= 1'b0;
            r_ion_pending <= 1'b0;
        end else if (w_done_internal && r_bits[1]) begin
            r_ion         <= 1'b0;
            r_ion_pending <= 1'b0;
        end else begin
            if (r_ion_pending && instr_fetch) begin
                r_ion <= 1'b1;
            end
            if (w_done_internal && r_bits[0]) begin
                r_ion_pending <= 1'b1;
            end else if (instr_fetch) begin
                r_ion_pending <= 1'b0;
            end
        end
    end

    // Lowest-numbered request wins.
    always_comb begin
        w_int_src = 2'd0;
        if (irq_in[0])      w_int_src = 2'd0;
        else if (irq_in[1]) w_int_src = 2'd1;
        else if (irq_in[2]) w_int_src = 2'd2;
        else if (irq_in[3]) w_int_src = 2'd3;
    end

    assign io_select = r_sel;
    assign iop       = r_iop;
    assign skip      = r_skip;
    assign ac_clear  = r_ac_clear;
    assign ac_load   = r_ac_load;
    assign ac_data   = r_ac_data;
    assign iot_done  = r_iot_done;
    assign ion       = r_ion;
    assign int_req   = r_ion & (|irq_in);
    assign int_src   = w_int_src;

endmodule
`default_nettype wire

// File: tb/tb_pdp8_iot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pdp8_iot_seq
//  Description : Self-checking bench for pdp8_iot_seq. A schedule-based model
//                (per-cycle expected IOP table built from the enabled phases)
//                predicts every output; directed scenarios are followed by a
//                randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pdp8_iot_seq;
    localparam int IOPC = 2;
    localparam int GAPC = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iot_start = 1'b0;
    logic [11:0] mb = 12'o0;
    logic        dev_skip = 1'b0, dev_clear_ac = 1'b0, dev_data_avail = 1'b0;
    logic [11:0] dev_data = 12'o0;
    logic [3:0]  irq_in = 4'b0;
    logic        instr_fetch = 1'b0, int_ack = 1'b0;
    logic [5:0]  io_select;
    logic [2:0]  iop;
    logic        skip, ac_clear, ac_load, iot_done, ion, int_req;
    logic [11:0] ac_data;
    logic [1:0]  int_src;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pdp8_iot_seq #(.IOP_CYCLES(IOPC), .GAP_CYCLES(GAPC)) dut (
        .clk(clk), .reset(reset), .iot_start(iot_start), .mb(mb),
        .io_select(io_select), .iop(iop),
        .dev_skip(dev_skip), .dev_clear_ac(dev_clear_ac),
        .dev_data_avail(dev_data_avail), .dev_data(dev_data),
        .skip(skip), .ac_clear(ac_clear), .ac_load(ac_load),
        .ac_data(ac_data), .iot_done(iot_done),
        .irq_in(irq_in), .instr_fetch(instr_fetch), .int_ack(int_ack),
        .ion(ion), .int_req(int_req), .int_src(int_src)
    );

    // ---------------- reference model ----------------
    bit          m_valid = 0;
    bit          m_busy = 0;
    int          m_t = 0;
    int          m_N = 0;
    logic [2:0]  sch_iop [0:31];
    bit          sch_last[0:31];
    logic [5:0]  m_sel = 0;
    logic [2:0]  m_bits = 0;
    logic [2:0]  m_iop = 0;
    logic        m_skip = 0, m_load = 0, m_clear = 0, m_done = 0;
    logic [11:0] m_acdata = 0;
    logic        m_ion = 0, m_pend = 0;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    // Expected IOP value for every cycle of the sequence, cycle 1 = SETUP.
    task automatic build_schedule();
        int t;
        for (int i = 0; i < 32; i++) begin
            sch_iop[i]  = 3'b000;
            sch_last[i] = 0;
        end
        t = 2;
        for (int b = 0; b < 3; b++) begin
            if (m_bits[b]) begin
                for (int k = 0; k < IOPC; k++) begin
                    sch_iop[t] = (m_sel == 6'o00) ? 3'b000 : 3'(1 << b);
                    t++;
                end
                sch_last[t-1] = 1;
                t += GAPC;
            end
        end
        m_N = t;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_next();
        bit done_now;
        bit internal;
        if (!reset) begin
            m_busy = 0; m_t = 0; m_sel = 0; m_bits = 0; m_iop = 0;
            m_skip = 0; m_load = 0; m_clear = 0; m_done = 0; m_acdata = 0;
            m_ion = 0; m_pend = 0; m_valid = 1;
        end else begin
            done_now = m_busy && (m_t == m_N);
            internal = (m_sel == 6'o00);
            if (m_pend && instr_fetch) begin m_ion = 1; m_pend = 0; end
            if (done_now && internal) begin
                if (m_bits[1])      begin m_ion = 0; m_pend = 0; end
                else if (m_bits[0]) m_pend = 1;
            end
            if (int_ack) begin m_ion = 0; m_pend = 0; end
            m_load = 0; m_clear = 0;
            if (!m_busy) begin
                if (iot_start) begin
                    m_busy = 1; m_t = 1; m_sel = mb[8:3]; m_bits = mb[2:0];
                    m_skip = 0;
                    build_schedule();
                end
            end else begin
                if (sch_last[m_t] && !internal) begin
                    m_skip  = m_skip | dev_skip;
                    m_load  = dev_data_avail;
                    m_clear = dev_clear_ac;
                    if (dev_data_avail) m_acdata = dev_data;
                end
                if (done_now) m_busy = 0;
                else          m_t++;
            end
            m_iop  = m_busy ? sch_iop[m_t] : 3'b000;
            m_done = m_busy && (m_t == m_N);
        end
    endtask

    task automatic check_comb();
        int src;
        src = 0;
        for (int i = 3; i >= 0; i--) if (irq_in[i]) src = i;
        if (m_valid) begin
            chk("int_req", {11'b0, int_req}, {11'b0, m_ion & (|irq_in)});
            chk("int_src", {10'b0, int_src}, 12'(src));
        end
    endtask

    task automatic check_regs();
        chk("io_select", {6'b0, io_select}, {6'b0, m_sel});
        chk("iop",       {9'b0, iop},       {9'b0, m_iop});
        chk("skip",      {11'b0, skip},     {11'b0, m_skip});
        chk("ac_clear",  {11'b0, ac_clear}, {11'b0, m_clear});
        chk("ac_load",   {11'b0, ac_load},  {11'b0, m_load});
        chk("ac_data",   ac_data,           m_acdata);
        chk("iot_done",  {11'b0, iot_done}, {11'b0, m_done});
        chk("ion",       {11'b0, ion},      {11'b0, m_ion});
    endtask

    // Inputs are set at a falling edge; one tick crosses one rising edge.
    task automatic tick();
        #1 check_comb();
        model_next();
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    // Start an IOT and return the cycle number in which iot_done was seen.
    task automatic run_iot(input logic [11:0] mbv, output int done_cyc);
        iot_start = 1'b1;
        mb = mbv;
        tick();
        iot_start = 1'b0;
        done_cyc = -1;
        for (int c = 1; c < 40; c++) begin
            if (iot_done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (!m_busy) break;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        chk("rst_iop", {9'b0, iop}, 12'd0);
        chk("rst_done", {11'b0, iot_done}, 12'd0);
        reset = 1'b1;
        tick();

        // Full 6037 on device 03: done in cycle 11.
        run_iot(12'o6037, dc);
        chk("done_cyc_6037", 12'(dc), 12'd11);

        // Device answers only during P2 of a 6037.
        iot_start = 1'b1; mb = 12'o6037;
        tick();
        iot_start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            dev_skip       = (c == 5 || c == 6);
            dev_data_avail = (c == 5 || c == 6);
            dev_data       = (c == 5 || c == 6) ? 12'o1234 : 12'o0;
            tick();
            if (c + 1 == 7) begin
                chk("ac_load_c7", {11'b0, ac_load}, 12'd1);
                chk("ac_data_c7", ac_data, 12'o1234);
                chk("skip_c7", {11'b0, skip}, 12'd1);
            end
        end
        dev_skip = 1'b0; dev_data_avail = 1'b0; dev_data = 12'o0;

        // 6032 with device always responding.
        dev_skip = 1'b1; dev_data_avail = 1'b1; dev_data = 12'o1234;
        run_iot(12'o6032, dc);
        chk("done_cyc_6032", 12'(dc), 12'd5);
        chk("skip_6032", {11'b0, skip}, 12'd1);
        dev_skip = 1'b0; dev_data_avail = 1'b0; dev_data = 12'o0;

        // 6030: no IOPs, plus a start request mid-sequence that is ignored.
        iot_start = 1'b1; mb = 12'o6030;
        tick();
        mb = 12'o6217;
        tick();
        chk("done_6030_c2", {11'b0, iot_done}, 12'd1);
        iot_start = 1'b0;
        tick();
        chk("sel_kept", {6'b0, io_select}, 12'o03);

        // ION with the one-instruction delay.
        irq_in = 4'b0010;
        run_iot(12'o6001, dc);
        chk("done_cyc_6001", 12'(dc), 12'd5);
        tick();
        chk("ion_delayed", {11'b0, ion}, 12'd0);
        chk("int_req_delayed", {11'b0, int_req}, 12'd0);
        instr_fetch = 1'b1;
        tick();
        instr_fetch = 1'b0;
        chk("ion_on", {11'b0, ion}, 12'd1);
        chk("int_req_on", {11'b0, int_req}, 12'd1);
        chk("int_src_on", {10'b0, int_src}, 12'd1);
        tick();

        // IOF clears ion.
        run_iot(12'o6002, dc);
        chk("ion_iof", {11'b0, ion}, 12'd0);

        // int_ack coinciding with the promotion wins, and nothing stays pending.
        run_iot(12'o6001, dc);
        instr_fetch = 1'b1; int_ack = 1'b1;
        tick();
        instr_fetch = 1'b0; int_ack = 1'b0;
        chk("ion_acked", {11'b0, ion}, 12'd0);
        tick();
        instr_fetch = 1'b1;
        tick();
        instr_fetch = 1'b0;
        chk("ion_no_pending", {11'b0, ion}, 12'd0);

        // Reset during P2, with a start request in the reset cycle.
        iot_start = 1'b1; mb = 12'o6037;
        tick();
        iot_start = 1'b0;
        repeat (4) tick();
        chk("iop_p2", {9'b0, iop}, 12'o2);
        reset = 1'b0; iot_start = 1'b1;
        tick();
        reset = 1'b1; iot_start = 1'b0;
        chk("rst_mid_iop", {9'b0, iop}, 12'd0);
        chk("rst_mid_sel", {6'b0, io_select}, 12'd0);
        tick();
        chk("rst_start_ignored", {6'b0, io_select}, 12'd0);
        run_iot(12'o6037, dc);
        chk("done_after_rst", 12'(dc), 12'd11);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [5:0] dev;
            case ($urandom_range(0, 3))
                0:       dev = 6'o00;
                1:       dev = 6'o03;
                default: dev = 6'($urandom);
            endcase
            reset          = ($urandom_range(0, 63) != 0);
            iot_start      = ($urandom_range(0, 2) == 0);
            mb             = {3'o6, dev, 3'($urandom)};
            dev_skip       = 1'($urandom);
            dev_clear_ac   = 1'($urandom);
            dev_data_avail = 1'($urandom);
            dev_data       = 12'($urandom);
            irq_in         = 4'($urandom);
            instr_fetch    = ($urandom_range(0, 3) == 0);
            int_ack        = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
